stream_mux_arb: RTL and testbench
=================================

Name: stream_mux_arb

Overview:
- Parametrised N-channel, W-bit streaming multiplexer with a registered output stage and a valid/ready handshake on every channel.
- Two selection modes: fixed select, steered by the sel port, and round-robin arbitration.
- Grant locks for the duration of a packet, from the first beat through the beat carrying last.
- Sits between multiple producer datapaths and a single shared consumer; successor to the fixed 4:1 x 2-bit combinational mux.

Parameters:
- N_CH, 4, number of input channels (2..16).
- W, 2, data width per channel in bits (1..64).
- SEL_W, $clog2(N_CH), width of the select and channel-index fields.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = fixed select via sel; 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- in_data  input  N_CH*W  channel k occupies bits [k*W +: W].
- in_valid  input  N_CH  per-channel valid.
- in_last  input  N_CH  per-channel end-of-packet flag.
- in_ready  output  N_CH  per-channel ready; combinational, at most one bit high.
- out_data  output  W  registered data.
- out_valid  output  1  registered valid.
- out_last  output  1  registered last.
- out_ch  output  SEL_W  index of the channel that produced the current output beat.
- out_ready  input  1  consumer ready.
- busy  output  1  high while in LOCKED state.

Behaviour:
- One clock domain (clk), synchronous active-high reset (rst).
- Reset values: out_valid=0, out_data=0, out_last=0, out_ch=0, busy=0, in_ready=all 0, state=IDLE, rr_ptr=N_CH-1 (so channel 0 has first priority).
- Reset asserted mid-packet drops the lock and the buffered beat; no partial beat is emitted afterwards.
- Output stage can load when (out_valid==0) or (out_ready==1).
- Transfer on channel g occurs when in_valid[g] && in_ready[g].
- in_ready[g] = (g == grant) && load_ok. All other in_ready bits are 0.
- Latency: a beat accepted in cycle t appears on out_* in cycle t+1.
- Full throughput: one beat per cycle while in_valid[g] and out_ready are both held high.
- out_valid holds with stable out_data/out_last/out_ch while out_ready==0. It clears when out_ready==1 and no new transfer occurs in the same cycle.
- Simultaneous consume of the current beat and load of the next beat is legal; the new beat overwrites the register.
- State IDLE, grant computation (combinational):
  - mode=0: grant=sel if sel<N_CH and in_valid[sel]; otherwise no grant.
  - mode=1: first k with in_valid[k] set, searching rr_ptr+1, rr_ptr+2, ... modulo N_CH; no grant if no valid.
- IDLE transitions:
  - Transfer with in_last=1 (single-beat packet): stay IDLE; rr_ptr<=g.
  - Transfer with in_last=0: go LOCKED; lock_ch<=g.
- State LOCKED:
  - grant=lock_ch regardless of mode, sel or other valids. Changes to mode/sel while LOCKED take effect only after returning to IDLE.
  - Transfer with in_last=1 -> IDLE; rr_ptr<=lock_ch.
  - in_valid[lock_ch] deasserting mid-packet keeps the lock; no transfer occurs and no other channel is served.
- rr_ptr updates only on packet completion, in either mode, so round-robin fairness resumes from the last completed packet after a mode switch.
- sel>=N_CH (possible when N_CH is not a power of two): no grant, all in_ready 0.
- busy = (state==LOCKED).

Test Plan:
- Reset then mode=0, sel=2, ch2 sends single beat data=2'b10 last=1, out_ready=1 -> in_ready=4'b0100 that cycle; next cycle out_valid=1, out_data=2'b10, out_ch=2, out_last=1.
- mode=1, all four channels valid with single-beat packets data=k, out_ready=1 -> grants in order 0,1,2,3,0; out_ch sequence 0,1,2,3,0 on consecutive cycles (throughput 1/cycle).
- mode=1, ch1 sends a 3-beat packet (last on beat 3) while ch0/ch2 are continuously valid -> out_ch=1 for 3 consecutive beats, busy=1 for 2 cycles, next grant is ch2.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1, data=2'b11 -> out_data stays 2'b11, in_ready all 0. Then out_ready=1 with the next beat pending -> back-to-back transfer without a bubble.
- Lock stability: mode=0, sel=1, ch1 starts a 2-beat packet; sel changes to 3 mid-packet and ch1 valid drops for 2 cycles -> no ch3 beats until ch1 sends last; afterwards ch3 is granted.
- Reset mid-packet: assert rst while LOCKED with out_valid=1 -> next cycle out_valid=0, busy=0, in_ready=0. After release, mode=1 grants ch0 first.

Source files
------------

// File: rtl/stream_mux_arb.sv
// N-channel valid/ready stream mux with fixed-select or round-robin
// arbitration, packet-level grant locking and a registered output stage.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   mode, sel        0 = fixed select on sel, 1 = round-robin
//   in_data          channel k occupies bits [k*W +: W]
//   in_valid/last    per-channel handshake and end-of-packet flag
//   in_ready         per-channel ready, at most one bit high
//   out_*            registered beat with source channel index out_ch
//   out_ready        consumer ready
//   busy             high while a packet holds the grant
module stream_mux_arb #(
    parameter int N_CH  = 4,
    parameter int W     = 2,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    input  logic [N_CH*W-1:0] in_data,
    input  logic [N_CH-1:0]   in_valid,
    input  logic [N_CH-1:0]   in_last,
    output logic [N_CH-1:0]   in_ready,
    output logic [W-1:0]      out_data,
    output logic              out_valid,
    output logic              out_last,
    output logic [SEL_W-1:0]  out_ch,
    input  logic              out_ready,
    output logic              busy
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;

    logic             load_ok;
    logic             gnt_vld;
    logic [SEL_W-1:0] gnt_ch;
    logic             rr_vld;
    logic [SEL_W-1:0] rr_ch;
    logic             fx_vld;
    logic [W-1:0]     g_data;
    logic             g_valid;
    logic             g_last;
    logic             xfer;

    // Reset gates ready so nothing is accepted while rst is held.
    assign load_ok = !rst && (!out_valid_q || out_ready);

    // Fixed select; sel values beyond N_CH-1 match no channel.
    always_comb begin
        fx_vld = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel == SEL_W'(k) && in_valid[k]) fx_vld = 1'b1;
        end
    end

    // Round-robin search from rr_ptr+1; walking the distance
    // downwards lets the nearest valid channel win.
    always_comb begin
        rr_vld = 1'b0;
        rr_ch  = '0;
        for (int i = N_CH; i >= 1; i--) begin
            int j;
            j = int'(rr_ptr_q) + i;
            if (j >= N_CH) j = j - N_CH;
            for (int k = 0; k < N_CH; k++) begin
                if (j == k && in_valid[k]) begin
                    rr_vld = 1'b1;
                    rr_ch  = SEL_W'(k);
                end
            end
        end
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        if (state_q == LOCKED) begin
            gnt_vld = 1'b1;
            gnt_ch  = lock_ch_q;
        end else if (mode) begin
            gnt_vld = rr_vld;
            gnt_ch  = rr_ch;
        end else begin
            gnt_vld = fx_vld;
            gnt_ch  = sel;
        end
    end

    always_comb begin
        in_ready = '0;
        g_data   = '0;
        g_valid  = 1'b0;
        g_last   = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (gnt_ch == SEL_W'(k)) begin
                in_ready[k] = gnt_vld && load_ok;
                g_data      = in_data[k*W +: W];
                g_valid     = in_valid[k];
                g_last      = in_last[k];
            end
        end
    end

    assign xfer = gnt_vld && load_ok && g_valid;

    always_comb begin
        state_d     = state_q;
        lock_ch_d   = lock_ch_q;
        rr_ptr_d    = rr_ptr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;
        if (load_ok) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = g_data;
                out_last_d = g_last;
                out_ch_d   = gnt_ch;
            end
        end
        case (state_q)
            IDLE: begin
                if (xfer && g_last) begin
                    rr_ptr_d = gnt_ch;
                end else if (xfer) begin
                    state_d   = LOCKED;
                    lock_ch_d = gnt_ch;
                end
            end
            LOCKED: begin
                if (xfer && g_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = lock_ch_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lock_ch_q   <= '0;
            rr_ptr_q    <= SEL_W'(N_CH - 1);
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            lock_ch_q   <= lock_ch_d;
            rr_ptr_q    <= rr_ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;
    assign busy      = (state_q == LOCKED);

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed self-checking bench for stream_mux_arb (N_CH=4, W=2).
// Inputs change 1 time unit after posedge; outputs sampled there too.
module tb_stream_mux_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic [1:0] sel;
    logic [7:0] in_data;
    logic [3:0] in_valid;
    logic [3:0] in_last;
    logic [3:0] in_ready;
    logic [1:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic [1:0] out_ch;
    logic       out_ready;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;

    stream_mux_arb #(.N_CH(4), .W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ch    (out_ch),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic out_chk(input string tag, input logic v,
                           input logic [1:0] d, input logic [1:0] c,
                           input logic l);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".data"},  32'(out_data),  32'(d));
        chk({tag, ".ch"},    32'(out_ch),    32'(c));
        chk({tag, ".last"},  32'(out_last),  32'(l));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; sel = '0; in_data = '0;
        in_valid = '0; in_last = '0; out_ready = 1'b0;
        tick();
        tick();
        out_chk("reset", 1'b0, 2'd0, 2'd0, 1'b0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;

        // fixed select, single beat on ch2
        mode = 1'b0; sel = 2'd2; in_data = 8'b00_10_00_00;
        in_valid = 4'b0100; in_last = 4'b0100; out_ready = 1'b1;
        #1 chk("fix.in_ready", 32'(in_ready), 32'b0100);
        tick();
        out_chk("fix.out", 1'b1, 2'b10, 2'd2, 1'b1);
        in_valid = '0;
        tick();
        chk("fix.drain", 32'(out_valid), 32'd0);

        // round-robin over four single-beat packets
        do_reset();
        mode = 1'b1; in_data = 8'b11_10_01_00;
        in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("rr.in_ready", 32'(in_ready), 32'(1 << (i % 4)));
            tick();
            out_chk("rr.out", 1'b1, 2'(i % 4), 2'(i % 4), 1'b1);
        end
        in_valid = '0;
        tick();

        // 3-beat packet on ch1 with ch0/ch2 competing (rr_ptr=0)
        in_data = 8'b00_10_01_00;
        in_valid = 4'b0111; in_last = 4'b0101;
        #1 chk("pkt.rdy0", 32'(in_ready), 32'b0010);
        chk("pkt.busy0", 32'(busy), 32'd0);
        tick();
        out_chk("pkt.b1", 1'b1, 2'b01, 2'd1, 1'b0);
        chk("pkt.busy1", 32'(busy), 32'd1);
        #1 chk("pkt.rdy1", 32'(in_ready), 32'b0010);
        tick();
        out_chk("pkt.b2", 1'b1, 2'b01, 2'd1, 1'b0);
        chk("pkt.busy2", 32'(busy), 32'd1);
        in_last = 4'b0111;
        #1 chk("pkt.rdy2", 32'(in_ready), 32'b0010);
        tick();
        out_chk("pkt.b3", 1'b1, 2'b01, 2'd1, 1'b1);
        chk("pkt.busy3", 32'(busy), 32'd0);
        #1 chk("pkt.next_rdy", 32'(in_ready), 32'b0100);
        tick();
        out_chk("pkt.next", 1'b1, 2'b10, 2'd2, 1'b1);
        in_valid = '0;
        tick();
        chk("pkt.drain", 32'(out_valid), 32'd0);

        // backpressure: ch3 beat held, then ch0 follows without bubble
        in_data = 8'b11_00_00_00; in_valid = 4'b1000; in_last = 4'b1111;
        out_ready = 1'b0;
        #1 chk("bp.rdy0", 32'(in_ready), 32'b1000);
        tick();
        in_data = 8'b00_00_00_01; in_valid = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            out_chk("bp.hold", 1'b1, 2'b11, 2'd3, 1'b1);
            chk("bp.rdy_hold", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1 chk("bp.rdy_go", 32'(in_ready), 32'b0001);
        tick();
        out_chk("bp.next", 1'b1, 2'b01, 2'd0, 1'b1);
        in_valid = '0;
        tick();

        // lock stability: sel moves to 3 and ch1 stalls mid-packet
        mode = 1'b0; sel = 2'd1; in_data = 8'b11_00_01_00;
        in_valid = 4'b1010; in_last = 4'b1000;
        #1 chk("lk.rdy0", 32'(in_ready), 32'b0010);
        tick();
        out_chk("lk.b1", 1'b1, 2'b01, 2'd1, 1'b0);
        chk("lk.busy1", 32'(busy), 32'd1);
        sel = 2'd3; in_valid = 4'b1000;
        #1 chk("lk.rdy_stall", 32'(in_ready), 32'b0010);
        tick();
        chk("lk.gap1", 32'(out_valid), 32'd0);
        chk("lk.busy_gap1", 32'(busy), 32'd1);
        tick();
        chk("lk.gap2", 32'(out_valid), 32'd0);
        chk("lk.busy_gap2", 32'(busy), 32'd1);
        in_valid = 4'b1010; in_last = 4'b1010;
        #1 chk("lk.rdy_last", 32'(in_ready), 32'b0010);
        tick();
        out_chk("lk.b2", 1'b1, 2'b01, 2'd1, 1'b1);
        chk("lk.busy_end", 32'(busy), 32'd0);
        #1 chk("lk.rdy_ch3", 32'(in_ready), 32'b1000);
        tick();
        out_chk("lk.ch3", 1'b1, 2'b11, 2'd3, 1'b1);
        in_valid = '0;
        tick();

        // reset while locked (rr_ptr=3 so ch2 is the only candidate)
        mode = 1'b1; in_data = 8'b00_10_00_00;
        in_valid = 4'b0100; in_last = 4'b0000;
        #1 chk("rs.rdy0", 32'(in_ready), 32'b0100);
        tick();
        chk("rs.busy_pre", 32'(busy), 32'd1);
        chk("rs.valid_pre", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        chk("rs.valid", 32'(out_valid), 32'd0);
        chk("rs.busy", 32'(busy), 32'd0);
        chk("rs.in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        in_data = 8'b00_10_01_00; in_valid = 4'b0111; in_last = 4'b1111;
        #1 chk("rs.rdy_after", 32'(in_ready), 32'b0001);
        tick();
        out_chk("rs.first", 1'b1, 2'b00, 2'd0, 1'b1);
        in_valid = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
